// File: rtl/conv_encoder_if.sv
// Handshake bundle for the convolutional encoder: information-bit input stream
// and coded-symbol output stream.
//   in_valid/in_ready/in_bit/in_last      : bit source -> encoder
//   out_valid/out_ready/out_a/out_b/out_last : encoder -> channel/decoder
// master = side that supplies bits and consumes symbols; slave = the encoder.
interface conv_encoder_if;
    logic in_valid;
    logic in_ready;
    logic in_bit;
    logic in_last;
    logic out_valid;
    logic out_ready;
    logic out_a;
    logic out_b;
    logic out_last;

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_last
    );

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_a, out_b, out_last
    );
endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with zero-tail frame termination.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - conv_encoder_if.slave: bit input stream, (a,b) symbol output stream
// Parameters: K constraint length (3..9), G0/G1 generators (MSB taps current bit).
module conv_encoder #(
    parameter int unsigned    K  = 3,
    parameter logic [K-1:0]   G0 = 3'b111,
    parameter logic [K-1:0]   G1 = 3'b101
) (
    input  logic            clk,
    input  logic            rst,
    conv_encoder_if.slave   bus
);

    localparam int unsigned SRW = K - 1;
    localparam int unsigned CW  = $clog2(K);
    localparam logic [CW-1:0] TAIL_LAST = CW'(K - 2);

    localparam logic [0:0] ST_DATA = 1'b0;
    localparam logic [0:0] ST_TAIL = 1'b1;

    logic [0:0]     state,     state_nxt;
    logic [CW-1:0]  tail_cnt,  tail_cnt_nxt;
    logic [SRW-1:0] sr,        sr_nxt;      // sr[SRW-1] is the most recent bit
    logic           out_valid, out_valid_nxt;
    logic           out_a,     out_a_nxt;
    logic           out_b,     out_b_nxt;
    logic           out_last,  out_last_nxt;

    logic           free_c;
    logic           encode_c;
    logic           u_c;
    logic [K-1:0]   v_c;

    // Output slot can take a new symbol; tail symbols do not consume input.
    assign free_c   = !out_valid || bus.out_ready;
    assign u_c      = (state == ST_DATA) ? bus.in_bit : 1'b0;
    assign v_c      = {u_c, sr};
    assign encode_c = free_c && ((state == ST_TAIL) || bus.in_valid);

    assign bus.in_ready  = (state == ST_DATA) && free_c;
    assign bus.out_valid = out_valid;
    assign bus.out_a     = out_a;
    assign bus.out_b     = out_b;
    assign bus.out_last  = out_last;

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        tail_cnt_nxt  = tail_cnt;
        sr_nxt        = sr;
        out_valid_nxt = out_valid;
        out_a_nxt     = out_a;
        out_b_nxt     = out_b;
        out_last_nxt  = out_last;

        if (encode_c) begin
            out_a_nxt     = ^(G0 & v_c);
            out_b_nxt     = ^(G1 & v_c);
            out_valid_nxt = 1'b1;
            out_last_nxt  = 1'b0;
            sr_nxt        = v_c[K-1:1];

            case (state)
                ST_DATA: begin
                    if (bus.in_last) begin
                        state_nxt    = ST_TAIL;
                        tail_cnt_nxt = '0;
                    end
                end
                ST_TAIL: begin
                    if (tail_cnt == TAIL_LAST) begin
                        out_last_nxt = 1'b1;
                        state_nxt    = ST_DATA;
                        tail_cnt_nxt = '0;
                    end else begin
                        tail_cnt_nxt = tail_cnt + CW'(1);
                    end
                end
                default: state_nxt = ST_DATA;
            endcase
        end else if (free_c) begin
            out_valid_nxt = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_DATA;
            tail_cnt  <= '0;
            sr        <= '0;
            out_valid <= 1'b0;
            out_a     <= 1'b0;
            out_b     <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            tail_cnt  <= tail_cnt_nxt;
            sr        <= sr_nxt;
            out_valid <= out_valid_nxt;
            out_a     <= out_a_nxt;
            out_b     <= out_b_nxt;
            out_last  <= out_last_nxt;
        end
    end

endmodule
